// File: rtl/datawidthconv_wide_to_narrow.sv
// rtl/datawidthconv_wide_to_narrow.sv - wide packet stream to addressed narrow writes; optional DATAWIDTHCONV_EMPTY_EN partial eop word
module datawidthconv_wide_to_narrow #(
  parameter int IN_WIDTH   = 512,
  parameter int OUT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_INC   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  snk_sop,
  input  logic                  snk_eop,
  input  logic                  snk_valid,
  output logic                  snk_ready,
  input  logic [IN_WIDTH-1:0]   snk_din,
`ifdef DATAWIDTHCONV_EMPTY_EN
  input  logic [$clog2(IN_WIDTH/OUT_WIDTH)-1:0] snk_empty,
`endif
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [OUT_WIDTH-1:0]  data_din,
  output logic                  data_we,
  input  logic                  data_ready,
  output logic                  pkt_done,
  output logic                  busy
);

  localparam int LANES = IN_WIDTH / OUT_WIDTH;
  localparam int LW    = $clog2(LANES);
  localparam int PW    = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // Buffered wide words; the sop word also carries the base address sampled at its transfer
  logic [IN_WIDTH-1:0]   mem_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
  logic [LW-1:0]         mem_last_q [FIFO_DEPTH];
  logic                  mem_sop_q  [FIFO_DEPTH];
  logic                  mem_eop_q  [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          snk_ready_q, open_q, open_d;
  logic          xfer, push, pop, fifo_empty;
  logic [LW-1:0] in_last;

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]         lane_q, lane_d, last_q, last_d;
  logic                  eop_q, eop_d, done_q, done_d;

  assign xfer       = snk_valid && snk_ready_q;
  assign push       = xfer && (snk_sop || open_q);
  assign fifo_empty = (count_q == '0);
  assign count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);

  assign snk_ready = snk_ready_q;
  assign data_we   = (state_q == ST_SHIFT);
  assign data_din  = word_q[IN_WIDTH-1 -: OUT_WIDTH];
  assign data_addr = addr_q;
  assign pkt_done  = done_q;
  assign busy      = !fifo_empty || (state_q == ST_SHIFT);

  // Index of the final lane to emit for the incoming word
  always_comb begin
    in_last = LW'(LANES - 1);
`ifdef DATAWIDTHCONV_EMPTY_EN
    if (snk_eop && (int'(snk_empty) < LANES))
      in_last = LW'(LANES - 1 - int'(snk_empty));
`endif
  end

  // Packet-open tracking: words outside a packet are dropped, sop always (re)opens
  always_comb begin
    open_d = open_q;
    if (push)
      open_d = !snk_eop;
  end

  // FIFO storage write (no reset needed, validity is tracked by count)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= snk_din;
      mem_addr_q[wr_ptr_q] <= base_addr;
      mem_last_q[wr_ptr_q] <= in_last;
      mem_sop_q[wr_ptr_q]  <= snk_sop;
      mem_eop_q[wr_ptr_q]  <= snk_eop;
    end
  end

  // Serialiser next state: emit lanes MSB-first, chain straight into the next word on the last lane
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    last_d  = last_q;
    eop_d   = eop_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pop = !fifo_empty;
      end
      ST_SHIFT: begin
        if (data_ready) begin
          addr_d = addr_q + ADDR_WIDTH'(ADDR_INC);
          if (lane_q == last_q) begin
            done_d = eop_q;
            pop    = !fifo_empty;
            if (fifo_empty)
              state_d = ST_IDLE;
          end else begin
            lane_d = lane_q + LW'(1);
            word_d = word_q << OUT_WIDTH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      state_d = ST_SHIFT;
      word_d  = mem_data_q[rd_ptr_q];
      lane_d  = '0;
      last_d  = mem_last_q[rd_ptr_q];
      eop_d   = mem_eop_q[rd_ptr_q];
      if (mem_sop_q[rd_ptr_q])
        addr_d = mem_addr_q[rd_ptr_q];
    end
  end

  // Control and serialiser registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      snk_ready_q <= 1'b0;
      open_q      <= 1'b0;
      state_q     <= ST_IDLE;
      word_q      <= '0;
      addr_q      <= '0;
      lane_q      <= '0;
      last_q      <= '0;
      eop_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q     <= count_d;
      snk_ready_q <= (count_d != (PW+1)'(FIFO_DEPTH));
      open_q      <= open_d;
      state_q     <= state_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      last_q      <= last_d;
      eop_q       <= eop_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_datawidthconv_wide_to_narrow.sv
// tb/tb_datawidthconv_wide_to_narrow.sv - directed bench with write-queue model for datawidthconv_wide_to_narrow
module tb_datawidthconv_wide_to_narrow;
  localparam int IW = 512, OW = 32, AW = 32, LANES = 16;

  logic          clk = 1'b0, reset = 1'b0;
  logic          snk_sop = 1'b0, snk_eop = 1'b0, snk_valid = 1'b0, data_ready = 1'b0;
  logic [IW-1:0] snk_din = '0;
  logic [AW-1:0] base_addr = '0;
`ifdef DATAWIDTHCONV_EMPTY_EN
  logic [3:0]    snk_empty = '0;
`endif
  logic          snk_ready, data_we, pkt_done, busy;
  logic [AW-1:0] data_addr;
  logic [OW-1:0] data_din;

  datawidthconv_wide_to_narrow dut (
    .clk(clk), .reset(reset), .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_valid(snk_valid),
    .snk_ready(snk_ready), .snk_din(snk_din),
`ifdef DATAWIDTHCONV_EMPTY_EN
    .snk_empty(snk_empty),
`endif
    .base_addr(base_addr), .data_addr(data_addr), .data_din(data_din), .data_we(data_we),
    .data_ready(data_ready), .pkt_done(pkt_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // data_ready pattern: 0 = always 1, 1 = toggle every cycle, 2 = held low
  int dr_mode = 0;
  always @(posedge clk) begin
    #1;
    data_ready = (dr_mode == 0) ? 1'b1 : (dr_mode == 1) ? !data_ready : 1'b0;
  end

  // Model: every accepted in-packet word expands into its list of expected writes
  typedef struct {
    logic [AW-1:0] a;
    logic [OW-1:0] d;
    bit            last;
  } wr_t;
  wr_t           q[$];
  bit            m_open = 0;
  logic [AW-1:0] m_cur = '0;

  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      m_open = 0;
    end else if (snk_valid && snk_ready) begin
      int n;
      n = LANES;
`ifdef DATAWIDTHCONV_EMPTY_EN
      if (snk_eop && snk_empty < LANES) n = LANES - snk_empty;
`endif
      if (snk_sop) begin
        m_open = 1;
        m_cur  = base_addr;
      end
      if (m_open) begin
        for (int l = 0; l < n; l++) begin
          wr_t w;
          w.a  = m_cur;
          w.d  = snk_din[IW-1-l*OW -: OW];
          w.last = snk_eop && (l == n - 1);
          q.push_back(w);
          m_cur = m_cur + 1;
        end
        if (snk_eop) m_open = 0;
      end
    end
  end

  // Per-cycle comparison of write port, pkt_done and busy against the model
  int            writes = 0, dones = 0, first_cyc = 0, last_cyc = 0, we_cyc = 0;
  logic [AW-1:0] first_addr = '0, last_addr = '0;
  logic [OW-1:0] first_data = '0;
  bit            we_seen = 0, pend_done = 0;

  always @(negedge clk) begin
    if (!reset) begin
      pend_done = 0;
    end else begin
      checks++;
      if (pkt_done !== pend_done) begin
        errors++;
        $display("FAIL pkt_done cyc=%0d got=%b exp=%b", cyc, pkt_done, pend_done);
      end
      if (pkt_done === 1'b1) dones++;
      checks++;
      if (busy !== (q.size() != 0)) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, q.size() != 0);
      end
      pend_done = 0;
      if (data_we === 1'b1) begin
        if (!we_seen) begin
          we_seen = 1;
          we_cyc  = cyc;
        end
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write cyc=%0d addr=%h data=%h", cyc, data_addr, data_din);
        end else begin
          if (data_addr !== q[0].a || data_din !== q[0].d) begin
            errors++;
            $display("FAIL write cyc=%0d got=%h/%h exp=%h/%h", cyc, data_addr, data_din, q[0].a, q[0].d);
          end
          if (data_ready) begin
            if (writes == 0) begin
              first_addr = data_addr;
              first_data = data_din;
              first_cyc  = cyc;
            end
            last_addr = data_addr;
            last_cyc  = cyc;
            writes++;
            pend_done = q[0].last;
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input int tag, input int w);
    logic [IW-1:0] d;
    for (int l = 0; l < LANES; l++)
      d[IW-1-l*OW -: OW] = {8'(tag), 8'(w), 8'(l), 8'h5A};
    return d;
  endfunction

  int push_cyc = 0;

  task automatic send(input bit sop, input bit eop, input logic [AW-1:0] base,
                      input int tag, input int w, input int emp);
    bit ok;
    int n;
    snk_sop = sop; snk_eop = eop; snk_din = mk(tag, w); base_addr = base;
`ifdef DATAWIDTHCONV_EMPTY_EN
    snk_empty = 4'(emp);
`endif
    snk_valid = 1'b1;
    ok = 0; n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = snk_ready;
      push_cyc = cyc;
      @(posedge clk); #1;
      n++;
    end
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout got=0 exp=1 tag=%0d word=%0d", tag, w);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || q.size() != 0) && n < 5000);
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    writes = 0; dones = 0; we_seen = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int t1_push;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_snk_ready", snk_ready, 0);
    chk("rst_data_we", data_we, 0);
    chk("rst_data_addr", data_addr, 0);
    chk("rst_data_din", data_din, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", snk_ready, 0);
    @(negedge clk);
    chk("ready_after_reset", snk_ready, 1);
    @(posedge clk); #1;

    // 32-word packet, free-running sink
    clear_stats();
    dr_mode = 0;
    t1_push = 0;
    for (int w = 0; w < 32; w++) begin
      send(w == 0, w == 31, 32'h100, 1, w, 0);
      if (w == 0) t1_push = push_cyc;
    end
    wait_idle();
    chk("t1_writes", writes, 512);
    chk("t1_first_addr", first_addr, 32'h100);
    chk("t1_first_data", first_data, 32'h0100005A);
    chk("t1_last_addr", last_addr, 32'h2FF);
    chk("t1_dones", dones, 1);
    chk("t1_latency", we_cyc - t1_push, 2);

    // toggling data_ready
    clear_stats();
    dr_mode = 1;
    for (int w = 0; w < 3; w++) send(w == 0, w == 2, 32'h300, 2, w, 0);
    wait_idle();
    chk("t2_writes", writes, 48);
    chk("t2_last_addr", last_addr, 32'h32F);
    chk("t2_dones", dones, 1);

    // sink fills while writes are blocked: one word in the serialiser plus four buffered
    dr_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    clear_stats();
    for (int w = 0; w < 5; w++) send(w == 0, w == 4, 32'h500, 3, w, 0);
    @(negedge clk);
    chk("t3_ready_full", snk_ready, 0);
    repeat (10) @(negedge clk);
    chk("t3_hold_we", data_we, 1);
    chk("t3_hold_addr", data_addr, 32'h500);
    chk("t3_hold_writes", writes, 0);
    chk("t3_ready_still", snk_ready, 0);
    @(posedge clk); #1;
    dr_mode = 0;
    wait_idle();
    chk("t3_writes", writes, 80);
    chk("t3_no_bubble", last_cyc - first_cyc + 1, 80);
    chk("t3_last_addr", last_addr, 32'h54F);
    chk("t3_dones", dones, 1);

    // words without sop are dropped; sop mid-packet restarts the address
    clear_stats();
    send(0, 0, 32'h0, 4, 0, 0);
    send(0, 1, 32'h0, 4, 1, 0);
    repeat (5) @(negedge clk);
    chk("t4_drop_writes", writes, 0);
    chk("t4_drop_busy", busy, 0);
    @(posedge clk); #1;
    send(1, 0, 32'h0, 4, 2, 0);
    send(0, 0, 32'h0, 4, 3, 0);
    send(1, 0, 32'h40, 4, 4, 0);
    send(0, 0, 32'h40, 4, 5, 0);
    send(0, 1, 32'h40, 4, 6, 0);
    wait_idle();
    chk("t4_writes", writes, 80);
    chk("t4_last_addr", last_addr, 32'h6F);
    chk("t4_dones", dones, 1);

    // reset pulse mid-packet
    clear_stats();
    send(1, 0, 32'h800, 5, 0, 0);
    send(0, 0, 32'h800, 5, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_we_after_rst", data_we, 0);
    chk("t5_busy_after_rst", busy, 0);
    repeat (5) @(negedge clk);
    chk("t5_no_done", dones, 0);
    @(posedge clk); #1;
    clear_stats();
    send(1, 0, 32'h900, 6, 0, 0);
    send(0, 1, 32'h900, 6, 1, 0);
    wait_idle();
    chk("t5_writes", writes, 32);
    chk("t5_first_addr", first_addr, 32'h900);
    chk("t5_dones", dones, 1);

`ifdef DATAWIDTHCONV_EMPTY_EN
    // partial eop word: 16 + (16-5) writes
    clear_stats();
    send(1, 0, 32'hA00, 7, 0, 0);
    send(0, 1, 32'hA00, 7, 1, 5);
    wait_idle();
    chk("t6_writes", writes, 27);
    chk("t6_last_addr", last_addr, 32'hA1A);
    chk("t6_dones", dones, 1);
`endif

    chk("model_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
